// File: rtl/audio_out_fifo.sv
// audio_out_fifo
//
// Purpose:
//   Output buffer between the stereo sample player and the audio codec
//   controller. Left/right sample pairs arrive as one-cycle strobes at the
//   playback sample rate. They are queued in a small circular buffer and
//   drained into the codec through its write_ready/write handshake. Each
//   write is followed by one HOLD cycle so the codec has time to update
//   write_ready. Peak throughput is therefore one pair every two clocks.
//   The block also reports buffer health: a sticky overflow flag and a
//   saturating count of starvation events.
//
// Optional feature (macro AUDIO_OUT_FILL_ZERO_EN):
//   When the macro is defined, a starved codec receives zero-valued writes
//   so it never drains. Each zero write is counted as an underrun.
//   When the macro is undefined, a starved codec is left idle. In that case
//   only the entry into starvation is counted.
//
// Ports:
//   clk              system clock
//   clear_b          asynchronous active-low reset
//   in_valid         one-cycle strobe, pair present on in_left/in_right
//   in_left          left sample  [DATA_W-1:0]
//   in_right         right sample [DATA_W-1:0]
//   in_ready         high while the buffer is not full (combinational)
//   mute             zero the data written to the codec this cycle
//   write_ready      codec controller can accept a pair this cycle
//   write            registered one-cycle write strobe to the codec
//   writedata_left   registered left data to the codec
//   writedata_right  registered right data to the codec
//   fifo_level       occupancy, 0..2**DEPTH_LOG2
//   overflow         sticky, a pair was dropped because the buffer was full
//   underrun_cnt     saturating count of starvation events

module audio_out_fifo #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  clear_b,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_left,
  input  logic [DATA_W-1:0]     in_right,
  output logic                  in_ready,
  input  logic                  mute,
  input  logic                  write_ready,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata_left,
  output logic [DATA_W-1:0]     writedata_right,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [15:0]           underrun_cnt
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  logic [DATA_W-1:0]     memLeft  [DEPTH];
  logic [DATA_W-1:0]     memRight [DEPTH];

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [DATA_W-1:0]     wdLeft_q, wdLeft_d;
  logic [DATA_W-1:0]     wdRight_q, wdRight_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           underrun_q, underrun_d;
  logic                  primed_q, primed_d;
`ifndef AUDIO_OUT_FILL_ZERO_EN
  logic                  starved_q, starved_d;
`endif

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic starve;

  // Full and empty are taken from the registered level. A push that arrives
  // while the buffer is full is dropped, even if a pop frees a slot on the
  // same edge.
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign push  = in_valid && !full;

  // Codec-side sequencer. IDLE either pops the head into the output
  // registers or detects starvation. HOLD is the single write-strobe cycle
  // that gives the codec time to react.
  always_comb begin
    state_d    = state_q;
    write_d    = 1'b0;
    wdLeft_d   = wdLeft_q;
    wdRight_d  = wdRight_q;
    underrun_d = underrun_q;
    primed_d   = primed_q;
    pop        = 1'b0;
    starve     = 1'b0;

    case (state_q)
      IDLE: begin
        if (write_ready && !empty) begin
          pop       = 1'b1;
          write_d   = 1'b1;
          wdLeft_d  = mute ? '0 : memLeft[rdPtr_q];
          wdRight_d = mute ? '0 : memRight[rdPtr_q];
          primed_d  = 1'b1;
          state_d   = HOLD;
        end else if (write_ready && empty) begin
          starve = 1'b1;
`ifdef AUDIO_OUT_FILL_ZERO_EN
          // Keep the codec fed with silence once playback has started.
          if (primed_q) begin
            write_d   = 1'b1;
            wdLeft_d  = '0;
            wdRight_d = '0;
            state_d   = HOLD;
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
          end
`else
          // Count only the first cycle of each starvation episode. Cycles
          // before the first real pop are start-up and are not counted.
          if (primed_q && !starved_q && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
          end
`endif
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef AUDIO_OUT_FILL_ZERO_EN
  assign starved_d = starve;
`endif

  // Buffer bookkeeping. The pointers wrap naturally at their width. The
  // level tracks pushes and pops independently, so a simultaneous push and
  // pop leaves it unchanged.
  always_comb begin
    wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    overflow_d = overflow_q | (in_valid && full);
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Sample storage. The storage has no reset because the pointers and the
  // level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      memLeft[wrPtr_q]  <= in_left;
      memRight[wrPtr_q] <= in_right;
    end
  end

  // State registers. An asynchronous clear empties the buffer and drops
  // any pending write strobe at once.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      write_q    <= 1'b0;
      wdLeft_q   <= '0;
      wdRight_q  <= '0;
      overflow_q <= 1'b0;
      underrun_q <= '0;
      primed_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      write_q    <= write_d;
      wdLeft_q   <= wdLeft_d;
      wdRight_q  <= wdRight_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      primed_q   <= primed_d;
    end
  end

`ifndef AUDIO_OUT_FILL_ZERO_EN
  // Remembers whether the previous cycle was starved, so that each
  // starvation episode is counted only once.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      starved_q <= 1'b0;
    end else begin
      starved_q <= starved_d;
    end
  end
`endif

  assign in_ready        = !full;
  assign write           = write_q;
  assign writedata_left  = wdLeft_q;
  assign writedata_right = wdRight_q;
  assign fifo_level      = level_q;
  assign overflow        = overflow_q;
  assign underrun_cnt    = underrun_q;

endmodule

// File: tb/tb_audio_out_fifo.sv
// tb_audio_out_fifo
//
// Directed testbench for audio_out_fifo in the default build, where starved
// cycles leave the codec idle. Inputs are driven and outputs are sampled on
// the falling clock edge. The DUT samples its inputs on the rising edge.

module tb_audio_out_fifo;

  localparam int DATA_W     = 24;
  localparam int DEPTH_LOG2 = 3;

  logic                clk = 1'b0;
  logic                clear_b;
  logic                in_valid;
  logic [DATA_W-1:0]   in_left;
  logic [DATA_W-1:0]   in_right;
  logic                in_ready;
  logic                mute;
  logic                write_ready;
  logic                write;
  logic [DATA_W-1:0]   writedata_left;
  logic [DATA_W-1:0]   writedata_right;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                overflow;
  logic [15:0]         underrun_cnt;

  int compared   = 0;
  int mismatched = 0;

  audio_out_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk            (clk),
    .clear_b        (clear_b),
    .in_valid       (in_valid),
    .in_left        (in_left),
    .in_right       (in_right),
    .in_ready       (in_ready),
    .mute           (mute),
    .write_ready    (write_ready),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underrun_cnt   (underrun_cnt)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Holds the block in reset for two cycles and releases it on a falling edge.
  task automatic doReset();
    @(negedge clk);
    clear_b     = 1'b0;
    in_valid    = 1'b0;
    write_ready = 1'b0;
    mute        = 1'b0;
    repeat (2) @(negedge clk);
    clear_b = 1'b1;
  endtask

  // Presents a one-cycle pair strobe. This task must be called on a falling
  // edge, and it returns on the next falling edge.
  task automatic pushPair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Every output must be cleared while reset is asserted.
  task automatic test_reset();
    clear_b = 1'b0;
    #5;
    compared++;
    if (write !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_write: got %0h expected 0", write);
    end
    compared++;
    if (writedata_left !== 24'h0 || writedata_right !== 24'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got %0h/%0h expected 0/0", writedata_left, writedata_right);
    end
    compared++;
    if (fifo_level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
    end
    compared++;
    if (overflow !== 1'b0 || underrun_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_health: got ovf=%0h und=%0d expected 0/0", overflow, underrun_cnt);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %0h expected 1", in_ready);
    end
    @(negedge clk);
    clear_b = 1'b1;
  endtask

  // A single pair pushed into an empty buffer reaches the codec two clocks
  // later. The buffer then starves, which is counted exactly once.
  task automatic test_single_write();
    doReset();
    write_ready = 1'b1;
    pushPair(24'h123456, 24'hABCDEF);
    compared++;
    if (write !== 1'b0 || fifo_level !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL single_first: got write=%0h level=%0d expected 0/1", write, fifo_level);
    end
    @(negedge clk);
    compared++;
    if (write !== 1'b1 || writedata_left !== 24'h123456 || writedata_right !== 24'hABCDEF) begin
      mismatched++;
      $display("[TB] FAIL single_write: got %0h %0h/%0h expected 1 123456/abcdef",
               write, writedata_left, writedata_right);
    end
    compared++;
    if (fifo_level !== 4'd0 || underrun_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL single_level: got level=%0d und=%0d expected 0/0", fifo_level, underrun_cnt);
    end
    @(negedge clk);
    compared++;
    if (write !== 1'b0 || writedata_left !== 24'h123456) begin
      mismatched++;
      $display("[TB] FAIL single_hold: got write=%0h left=%0h expected 0/123456", write, writedata_left);
    end
    @(negedge clk);
    compared++;
    if (underrun_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL single_underrun: got %0d expected 1", underrun_cnt);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (underrun_cnt !== 16'd1 || write !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_underrun_once: got und=%0d write=%0h expected 1/0", underrun_cnt, write);
    end
  endtask

  // Ten pairs are pushed into a buffer of depth 8. The last two are
  // dropped, and the first eight drain in order, two clocks apart.
  task automatic test_overflow();
    int nWrites;
    int lastCyc;
    doReset();
    write_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      pushPair(24'(i), 24'(i + 'h100));
    end
    compared++;
    if (fifo_level !== 4'd8 || in_ready !== 1'b0 || overflow !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ovf_full: got level=%0d rdy=%0h ovf=%0h expected 8/0/1",
               fifo_level, in_ready, overflow);
    end
    write_ready = 1'b1;
    nWrites = 0;
    lastCyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (write === 1'b1) begin
        compared++;
        if (writedata_left !== 24'(nWrites + 1) || writedata_right !== 24'(nWrites + 1 + 'h100)) begin
          mismatched++;
          $display("[TB] FAIL ovf_order: got %0h/%0h expected %0h/%0h",
                   writedata_left, writedata_right, nWrites + 1, nWrites + 1 + 'h100);
        end
        if (nWrites > 0) begin
          compared++;
          if (cyc - lastCyc != 2) begin
            mismatched++;
            $display("[TB] FAIL ovf_spacing: got %0d expected 2", cyc - lastCyc);
          end
        end
        lastCyc = cyc;
        nWrites++;
      end
    end
    compared++;
    if (nWrites != 8) begin
      mismatched++;
      $display("[TB] FAIL ovf_count: got %0d expected 8", nWrites);
    end
    compared++;
    if (overflow !== 1'b1 || fifo_level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL ovf_sticky: got ovf=%0h level=%0d expected 1/0", overflow, fifo_level);
    end
  endtask

  // With four pairs buffered, a push and a pop on the same edge leave the
  // level at 4. Twenty more pairs then stream through, so the pointers wrap
  // several times. The drained data is checked against an in-order
  // scoreboard.
  task automatic test_simultaneous();
    logic [2*DATA_W-1:0] expQ[$];
    logic [2*DATA_W-1:0] exp;
    int                  pushesLeft;
    int                  nWrites;
    int                  v;
    doReset();
    write_ready = 1'b0;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      expQ.push_back({24'(24'h010000 + v), 24'(24'h020000 + v)});
      pushPair(24'(24'h010000 + v), 24'(24'h020000 + v));
      v++;
    end
    compared++;
    if (fifo_level !== 4'd4) begin
      mismatched++;
      $display("[TB] FAIL simul_prefill: got %0d expected 4", fifo_level);
    end
    write_ready = 1'b1;
    expQ.push_back({24'(24'h010000 + v), 24'(24'h020000 + v)});
    pushPair(24'(24'h010000 + v), 24'(24'h020000 + v));
    v++;
    compared++;
    if (fifo_level !== 4'd4 || write !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL simul_level: got level=%0d write=%0h expected 4/1", fifo_level, write);
    end
    exp = expQ.pop_front();
    compared++;
    if ({writedata_left, writedata_right} !== exp) begin
      mismatched++;
      $display("[TB] FAIL simul_head: got %0h expected %0h", {writedata_left, writedata_right}, exp);
    end
    pushesLeft = 20;
    nWrites    = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pushesLeft > 0 && (cyc % 2) == 0) begin
        in_valid = 1'b1;
        in_left  = 24'(24'h010000 + v);
        in_right = 24'(24'h020000 + v);
        expQ.push_back({in_left, in_right});
        v++;
        pushesLeft--;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (write === 1'b1) begin
        nWrites++;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL wrap_extra: got write with data %0h expected none", {writedata_left, writedata_right});
        end else begin
          exp = expQ.pop_front();
          if ({writedata_left, writedata_right} !== exp) begin
            mismatched++;
            $display("[TB] FAIL wrap_order: got %0h expected %0h", {writedata_left, writedata_right}, exp);
          end
        end
      end
      if (pushesLeft == 0 && expQ.size() == 0) break;
    end
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (nWrites != 24 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_drained: got writes=%0d level=%0d ovf=%0h expected 24/0/0",
               nWrites, fifo_level, overflow);
    end
  endtask

  // Mute zeroes the data written to the codec but still consumes the pair.
  task automatic test_mute();
    doReset();
    write_ready = 1'b0;
    pushPair(24'h111111, 24'h222222);
    pushPair(24'h7FFFFF, 24'h800000);
    compared++;
    if (fifo_level !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL mute_prefill: got %0d expected 2", fifo_level);
    end
    write_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (write !== 1'b1 || writedata_left !== 24'h111111 || writedata_right !== 24'h222222 ||
        fifo_level !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL mute_unmuted: got %0h %0h/%0h lvl=%0d expected 1 111111/222222 lvl=1",
               write, writedata_left, writedata_right, fifo_level);
    end
    mute = 1'b1;
    @(negedge clk);
    compared++;
    if (write !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mute_gap: got %0h expected 0", write);
    end
    @(negedge clk);
    compared++;
    if (write !== 1'b1 || writedata_left !== 24'h0 || writedata_right !== 24'h0 ||
        fifo_level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL mute_zero: got %0h %0h/%0h lvl=%0d expected 1 0/0 lvl=0",
               write, writedata_left, writedata_right, fifo_level);
    end
    mute = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (underrun_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL mute_underrun: got %0d expected 1", underrun_cnt);
    end
  endtask

  // Reset is asserted in the middle of a HOLD cycle with five pairs
  // buffered, overflow set and one underrun counted. Everything must clear
  // without waiting for a clock edge.
  task automatic test_reset_mid_hold();
    int nWrites;
    write_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pushPair(24'(24'h300000 + i), 24'(24'h400000 + i));
    end
    compared++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || underrun_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL hold_setup: got lvl=%0d ovf=%0h und=%0d expected 8/1/1",
               fifo_level, overflow, underrun_cnt);
    end
    write_ready = 1'b1;
    nWrites = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (write === 1'b1) nWrites++;
      if (nWrites == 3) break;
    end
    compared++;
    if (nWrites != 3 || fifo_level !== 4'd5 || write !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_reach: got writes=%0d lvl=%0d write=%0h expected 3/5/1",
               nWrites, fifo_level, write);
    end
    clear_b = 1'b0;
    #2;
    compared++;
    if (write !== 1'b0 || writedata_left !== 24'h0 || writedata_right !== 24'h0) begin
      mismatched++;
      $display("[TB] FAIL hold_clear_write: got %0h %0h/%0h expected 0 0/0",
               write, writedata_left, writedata_right);
    end
    compared++;
    if (fifo_level !== 4'd0 || overflow !== 1'b0 || underrun_cnt !== 16'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_clear_state: got lvl=%0d ovf=%0h und=%0d rdy=%0h expected 0/0/0/1",
               fifo_level, overflow, underrun_cnt, in_ready);
    end
    @(negedge clk);
    write_ready = 1'b0;
    clear_b     = 1'b1;
  endtask

  // Safety net in case the design hangs the sequence.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clear_b     = 1'b0;
    in_valid    = 1'b0;
    in_left     = '0;
    in_right    = '0;
    mute        = 1'b0;
    write_ready = 1'b0;
    test_reset();
    test_single_write();
    test_overflow();
    test_simultaneous();
    test_mute();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/audio_out_fifo.md
Name: audio_out_fifo

Overview:
- Downstream stage of the stereo sample player: buffers 24-bit left/right sample pairs produced at the ~44.1 kHz sample pulse.
- Drains the buffer into the audio codec controller using its write_ready/write handshake.
- Decouples the playback clock-enable domain from codec back-pressure and reports overflow and underrun health.

Parameters:
- DATA_W, 24, sample width per channel.
- DEPTH_LOG2, 3, log2 of FIFO depth in stereo pairs (default depth 8).

Ports:
- clk  input  1  system clock (50 MHz).
- clear_b  input  1  asynchronous active-low reset.
- in_valid  input  1  one-cycle strobe: sample pair present on in_left/in_right.
- in_left  input  DATA_W  left sample.
- in_right  input  DATA_W  right sample.
- in_ready  output  1  combinational, high when FIFO not full.
- mute  input  1  force written codec data to zero.
- write_ready  input  1  codec controller can accept a pair this cycle.
- write  output  1  registered one-cycle write strobe to codec.
- writedata_left  output  DATA_W  registered left data to codec.
- writedata_right  output  DATA_W  registered right data to codec.
- fifo_level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky: a pair was dropped.
- underrun_cnt  output  16  saturating count of starvation events.

Behaviour:
- Reset (clear_b low, asynchronous): FIFO empty, fifo_level=0, write=0, writedata_left/right=0, overflow=0, underrun_cnt=0, FSM in IDLE. Reset mid-write discards the FIFO contents and any pending strobe.
- FIFO storage: circular buffer with DEPTH_LOG2-bit read/write pointers. Pointers wrap modulo depth. Full/empty are derived from fifo_level.
- Push: when in_valid && !full, store the pair at wr_ptr and increment it.
- Push when full: when in_valid && full, drop the pair and set overflow to 1. overflow holds until reset.
- Full is evaluated at the start of the cycle. A push arriving while full is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop (not full, not empty): both occur and fifo_level is unchanged.
- FSM states: IDLE, HOLD.
- IDLE with write_ready && !empty:
  - Register the head pair into writedata_left/right (zero if mute=1 that cycle).
  - Assert write for the next cycle, pop the head, go to HOLD.
- HOLD: write=1 for exactly this one cycle, then unconditionally return to IDLE. This gives the codec one cycle to update write_ready. Maximum throughput is one pair per 2 clocks.
- Latency: a pair pushed into an empty FIFO with write_ready high appears with write=1 two clocks after the in_valid cycle.
- writedata_left/right hold their last value while write=0.
- Starvation: in IDLE with write_ready && empty.
  - underrun_cnt increments once on each entry into starvation, i.e. when the previous cycle was not starved. It saturates at 16'hFFFF.
  - No starvation is counted before the first successful pop after reset, which masks startup.
- Any FIFO capacity is usable; mute does not affect FIFO occupancy.

Optional Feature:
- Macro: AUDIO_OUT_FILL_ZERO_EN.
- Defined: starvation in IDLE performs a write of zero data (IDLE→HOLD, write pulse, writedata=0) instead of idling, so the codec never drains. underrun_cnt increments once per zero write, saturating, with the same startup masking.
- Undefined: starvation idles with write=0 and is counted per entry as above.

Test Plan:
- Reset, then write_ready=1 and a single push L=24'h123456, R=24'hABCDEF → write=1 exactly 2 clocks later with that data; fifo_level returns to 0; underrun_cnt=1 after the FIFO empties (macro undefined).
- write_ready=0, 10 pushes (values 1..10) → fifo_level=8, in_ready=0, overflow=1. Then write_ready=1 → exactly 8 writes, values 1..8 in order, spaced 2 clocks apart.
- FIFO at level 4, one push and one pop in the same cycle → level stays 4 and data order is preserved across pointer wrap (push 20 pairs through at depth 8).
- mute=1 during pop of a pair 24'h7FFFFF/24'h800000 → writedata both 0, write=1, fifo_level decrements.
- clear_b pulsed low mid-HOLD with level 5 → write, writedata, fifo_level, overflow and underrun_cnt all 0 immediately, without waiting for a clock edge.
- With AUDIO_OUT_FILL_ZERO_EN, after one real write and empty FIFO with write_ready=1 for 10 clocks → 5 zero writes and underrun_cnt=5.
